// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor width, direction codes (also used by the HEX display) and FSM states
package elevator_pkg;
    localparam int FLOOR_W = 6;
    localparam logic [1:0] DIR_UP   = 2'b00;
    localparam logic [1:0] DIR_STOP = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE_UP = 2'd1, MOVE_DOWN = 2'd2, DOOR_OPEN = 2'd3} state_t;
endpackage

// File: rtl/elevator_req_tracker.sv
// elevator_req_tracker: latched floor calls plus above/below/here flags relative to the car
module elevator_req_tracker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  clr_en,
    input  logic [FLOOR_W-1:0]    clr_floor,
    output logic [NUM_FLOORS-1:0] pending_mask,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  hit_here,
    output logic                  clr_hit
);
    logic [NUM_FLOORS-1:0] req_vec, clr_vec, calls;
    // Decode this cycle's call and clear target; out-of-range floors match no bit and vanish.
    always_comb begin
        req_vec   = '0;
        clr_vec   = '0;
        calls     = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        hit_here  = 1'b0;
        clr_hit   = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            req_vec[i] = req_valid && (req_floor == FLOOR_W'(i + 1));
            clr_vec[i] = clr_en && (clr_floor == FLOOR_W'(i + 1));
            calls[i]   = pending_mask[i] | req_vec[i];
            any_above  = any_above | (calls[i] && (FLOOR_W'(i + 1) > current_floor));
            any_below  = any_below | (calls[i] && (FLOOR_W'(i + 1) < current_floor));
            hit_here   = hit_here | (req_vec[i] && (FLOOR_W'(i + 1) == current_floor));
            clr_hit    = clr_hit | (calls[i] && clr_vec[i]);
        end
    end
    // A call arriving together with a clear of its floor is serviced, never latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_mask <= '0;
        else        pending_mask <= calls & ~clr_vec;
    end
endmodule

// File: rtl/elevator_floor_scheduler.sv
// elevator_floor_scheduler: SCAN car sequencer with travel and door timers (optional ELEV_DOOR_HOLD_EN)
module elevator_floor_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 32,
    parameter int FLOOR_TICKS = 50,
    parameter int DOOR_TICKS  = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [1:0]            report_dir,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending_mask
);
    localparam int MAX_T = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TW    = $clog2(MAX_T + 1);

    state_t             state, state_n, go_state, rev_state;
    logic [TW-1:0]      cnt, cnt_n;
    logic [FLOOR_W-1:0] floor_n, next_floor;
    logic [1:0]         last_dir, dir_n, rev_dir;
    logic               arrive, clr_en, any_above, any_below, hit_here, clr_hit, ahead, behind, hold;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    logic door_hold_unused;
    assign door_hold_unused = door_hold;
    assign hold = 1'b0;
`endif

    // Idle and door states swallow calls for the car's own floor; an arrival swallows calls for the new floor.
    assign arrive     = (state == MOVE_UP || state == MOVE_DOWN) && cnt == TW'(FLOOR_TICKS - 1);
    assign next_floor = state == MOVE_UP ? current_floor + FLOOR_W'(1) :
                        state == MOVE_DOWN ? current_floor - FLOOR_W'(1) : current_floor;
    assign clr_en     = state == IDLE || state == DOOR_OPEN || arrive;
    assign ahead      = last_dir == DIR_UP ? any_above : any_below;
    assign behind     = last_dir == DIR_UP ? any_below : any_above;
    assign go_state   = last_dir == DIR_UP ? MOVE_UP : MOVE_DOWN;
    assign rev_state  = last_dir == DIR_UP ? MOVE_DOWN : MOVE_UP;
    assign rev_dir    = last_dir == DIR_UP ? DIR_DOWN : DIR_UP;
    assign report_dir = state == MOVE_UP ? DIR_UP : state == MOVE_DOWN ? DIR_DOWN : DIR_STOP;
    assign door_open  = state == DOOR_OPEN;

    elevator_req_tracker #(.NUM_FLOORS(NUM_FLOORS)) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_floor    (req_floor),
        .current_floor(current_floor),
        .clr_en       (clr_en),
        .clr_floor    (next_floor),
        .pending_mask (pending_mask),
        .any_above    (any_above),
        .any_below    (any_below),
        .hit_here     (hit_here),
        .clr_hit      (clr_hit)
    );

    // SCAN policy: keep going in last_dir while calls lie ahead, reverse only when none remain.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        floor_n = current_floor;
        dir_n   = last_dir;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (hit_here) state_n = DOOR_OPEN;
                else if (ahead) state_n = go_state;
                else if (behind) begin
                    state_n = rev_state;
                    dir_n   = rev_dir;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                cnt_n   = arrive ? '0 : cnt + 1'b1;
                floor_n = arrive ? next_floor : current_floor;
                state_n = (arrive && clr_hit) ? DOOR_OPEN : state;
            end
            DOOR_OPEN: begin
                if (hit_here || hold) cnt_n = '0;
                else if (cnt == TW'(DOOR_TICKS - 1)) begin
                    cnt_n   = '0;
                    state_n = ahead ? go_state : behind ? rev_state : IDLE;
                    dir_n   = (!ahead && behind) ? rev_dir : last_dir;
                end
                else cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Car state register; reset drops the car straight back to floor 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            current_floor <= FLOOR_W'(1);
            last_dir      <= DIR_UP;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            current_floor <= floor_n;
            last_dir      <= dir_n;
        end
    end
endmodule

// File: tb/tb_elevator_floor_scheduler.sv
// tb_elevator_floor_scheduler: directed stimulus with a stop scoreboard checked by a door monitor
module tb_elevator_floor_scheduler;
    localparam int NF = 32;
`ifdef ELEV_DOOR_HOLD_EN
    localparam int HOLD_LEN = 28;
`else
    localparam int HOLD_LEN = 8;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [5:0]    req_floor = 6'd0;
    logic          door_hold = 1'b0;
    logic [5:0]    current_floor;
    logic [1:0]    report_dir;
    logic          door_open;
    logic [NF-1:0] pending_mask;

    typedef struct {int floor; int len;} stop_t;
    stop_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    max_floor = 1;
    int    min_floor = 1;
    int    door_len = 0;
    logic  door_prev = 1'b0;

    elevator_floor_scheduler #(.NUM_FLOORS(NF), .FLOOR_TICKS(4), .DOOR_TICKS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_floor    (req_floor),
        .door_hold    (door_hold),
        .current_floor(current_floor),
        .report_dir   (report_dir),
        .door_open    (door_open),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic call(input int f);
        req_valid = 1'b1;
        req_floor = 6'(f);
        @(negedge clk);
        req_valid = 1'b0;
        req_floor = 6'd0;
    endtask

    task automatic push_stop(input int f, input int len);
        stop_t s;
        s.floor = f;
        s.len = len;
        exp_q.push_back(s);
    endtask

    task automatic wait_floor(input int f, input int budget, input string name);
        int i = 0;
        while (int'(current_floor) != f && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, int'(current_floor), f);
    endtask

    task automatic wait_door(input logic v, input int budget, input string name);
        int i = 0;
        while (door_open != v && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, int'(door_open), int'(v));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i = 0;
        while (!(report_dir == 2'b01 && !door_open) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, int'({door_open, report_dir}), 1);
    endtask

    // Monitor: each door opening is a stop; floor and open time are checked against the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            door_prev = 1'b0;
            door_len = 0;
        end else begin
            if (int'(current_floor) > max_floor) max_floor = int'(current_floor);
            if (int'(current_floor) < min_floor) min_floor = int'(current_floor);
            if (door_open && !door_prev) begin
                door_len = 1;
                if (exp_q.size() == 0) check("unexpected_stop", int'(current_floor), 0);
                else check("stop_floor", int'(current_floor), exp_q[0].floor);
            end else if (door_open) begin
                door_len++;
            end else if (door_prev && exp_q.size() > 0) begin
                check("door_cycles", door_len, exp_q[0].len);
                void'(exp_q.pop_front());
            end
            door_prev = door_open;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_floor", int'(current_floor), 1);
        check("rst_dir", int'(report_dir), 1);
        check("rst_door", int'(door_open), 0);
        check("rst_mask", int'(pending_mask), 0);
        rst_n = 1'b1;
        tick(2);
        check("rel_floor", int'(current_floor), 1);
        check("rel_dir", int'(report_dir), 1);
        check("rel_door", int'(door_open), 0);
        check("rel_mask", int'(pending_mask), 0);
        call(20);
        wait_floor(7, 100, "reach_7");
        #2 rst_n = 1'b0;
        #1;
        check("async_floor", int'(current_floor), 1);
        check("async_mask", int'(pending_mask), 0);
        check("async_dir", int'(report_dir), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        push_stop(5, 8);
        call(5);
        check("t2_dir_up", int'(report_dir), 0);
        check("t2_mask", int'(pending_mask), 32'h10);
        tick(15);
        check("t2_floor4", int'(current_floor), 4);
        tick(1);
        check("t2_floor5", int'(current_floor), 5);
        check("t2_door", int'(door_open), 1);
        check("t2_dir_stop", int'(report_dir), 1);
        check("t2_mask_clr", int'(pending_mask), 0);
        wait_idle(100, "t2_idle");
        push_stop(10, 8);
        push_stop(3, 8);
        call(10);
        call(3);
        check("t3_mask", int'(pending_mask), 32'h204);
        wait_door(1'b1, 100, "t3_door10");
        wait_door(1'b0, 100, "t3_close10");
        check("t3_dir_down", int'(report_dir), 2);
        wait_idle(200, "t3_idle");
        check("t3_floor", int'(current_floor), 3);
        push_stop(4, 8);
        call(4);
        wait_idle(100, "t4_idle_a");
        push_stop(4, 8);
        call(4);
        check("t4_door", int'(door_open), 1);
        check("t4_floor", int'(current_floor), 4);
        check("t4_mask", int'(pending_mask), 0);
        wait_idle(100, "t4_idle_b");
        call(0);
        check("t4_mask0", int'(pending_mask), 0);
        call(33);
        check("t4_mask33", int'(pending_mask), 0);
        tick(10);
        check("t4_stay_floor", int'(current_floor), 4);
        check("t4_stay_dir", int'(report_dir), 1);
        push_stop(1, 8);
        call(1);
        wait_idle(100, "t5_idle_1");
        push_stop(32, 8);
        call(32);
        tick(123);
        check("t5_floor31", int'(current_floor), 31);
        check("t5_bit31_set", int'(pending_mask[31]), 1);
        call(32);
        check("t5_floor32", int'(current_floor), 32);
        check("t5_door", int'(door_open), 1);
        check("t5_mask", int'(pending_mask), 0);
        wait_idle(100, "t5_idle_32");
        push_stop(2, 8);
        call(2);
        wait_idle(300, "t6_idle_2");
        push_stop(2, HOLD_LEN);
        call(2);
        check("t6_door", int'(door_open), 1);
        door_hold = 1'b1;
        tick(20);
        door_hold = 1'b0;
        wait_idle(100, "t6_idle");
        tick(3);
        check("queue_empty", exp_q.size(), 0);
        check("max_floor", max_floor, 32);
        check("min_floor", min_floor, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
